uart_time_cmd_parser: RTL

- Command parser between the UART receiver (`bu_rx_data`/`bu_rx_data_rdy`) and the lab clock/alarm datapath.
- Turns an ASCII command stream into validated BCD load values for the clock time and alarm time:
  - `t`/`T` + 4 digits (MMSS) loads the time.
  - `a`/`A` + 4 digits loads the alarm.
- Malformed or stalled commands are rejected with an error pulse.
- Optionally echoes consumed characters toward the transmit/video-buffer path.

---
 rtl/uart_time_cmd_parser.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/uart_time_cmd_parser.sv
// ASCII time/alarm command parser: "t"/"a" + MMSS digits -> BCD load strobes.
// Optional byte echo toward the TX/video path when RX_ECHO_EN is defined.
module uart_time_cmd_parser #(
  parameter int unsigned TIMEOUT_CYC = 12000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bu_rx_data_rdy,
  input  logic [7:0] bu_rx_data,
  output logic       ld_time,
  output logic       ld_alarm,
  output logic [3:0] ld_Mtens,
  output logic [3:0] ld_Mones,
  output logic [3:0] ld_Stens,
  output logic [3:0] ld_Sones,
  output logic       cmd_err,
  output logic [7:0] echo_data,
  output logic       echo_rdy
);

  localparam logic [2:0]  S_IDLE  = 3'd0;
  localparam logic [2:0]  S_D0    = 3'd1;
  localparam logic [2:0]  S_D1    = 3'd2;
  localparam logic [2:0]  S_D2    = 3'd3;
  localparam logic [2:0]  S_D3    = 3'd4;
  localparam logic [7:0]  ESC     = 8'h1B;
  localparam logic [23:0] TO_LAST = 24'(TIMEOUT_CYC - 1);

  logic [2:0]  state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic        cmd_alarm_q, cmd_alarm_d;
  logic [3:0]  sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d;
  logic [3:0]  mt_q, mt_d, mo_q, mo_d, st_q, st_d, so_q, so_d;
  logic        ld_time_q, ld_time_d;
  logic        ld_alarm_q, ld_alarm_d;
  logic        cmd_err_q, cmd_err_d;

  logic       is_cmd, is_alarm_letter, is_dig;
  logic [3:0] lim;
  logic [3:0] nib;

  assign is_alarm_letter = (bu_rx_data == 8'h61) || (bu_rx_data == 8'h41);
  assign is_cmd          = is_alarm_letter || (bu_rx_data == 8'h74) || (bu_rx_data == 8'h54);
  // Tens positions (D0, D2) only allow 0-5.
  assign lim    = ((state_q == S_D0) || (state_q == S_D2)) ? 4'd5 : 4'd9;
  assign nib    = bu_rx_data[3:0];
  assign is_dig = (bu_rx_data[7:4] == 4'h3) && (nib <= lim);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_alarm_d = cmd_alarm_q;
    sh0_d       = sh0_q;
    sh1_d       = sh1_q;
    sh2_d       = sh2_q;
    mt_d        = mt_q;
    mo_d        = mo_q;
    st_d        = st_q;
    so_d        = so_q;
    ld_time_d   = 1'b0;
    ld_alarm_d  = 1'b0;
    cmd_err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bu_rx_data_rdy && is_cmd) begin
          state_d     = S_D0;
          cmd_alarm_d = is_alarm_letter;
        end
      end
      S_D0, S_D1, S_D2, S_D3: begin
        if (bu_rx_data_rdy) begin
          cnt_d = '0;
          if (bu_rx_data == ESC) begin
            state_d = S_IDLE;
            sh0_d   = '0;
            sh1_d   = '0;
            sh2_d   = '0;
          end else if (is_dig) begin
            if (state_q == S_D0) begin
              sh0_d   = nib;
              state_d = S_D1;
            end else if (state_q == S_D1) begin
              sh1_d   = nib;
              state_d = S_D2;
            end else if (state_q == S_D2) begin
              sh2_d   = nib;
              state_d = S_D3;
            end else begin
              // Last digit goes straight to the output with the shadow.
              mt_d       = sh0_q;
              mo_d       = sh1_q;
              st_d       = sh2_q;
              so_d       = nib;
              ld_time_d  = ~cmd_alarm_q;
              ld_alarm_d = cmd_alarm_q;
              state_d    = S_IDLE;
            end
          end else begin
            cmd_err_d = 1'b1;
            state_d   = S_IDLE;
            sh0_d     = '0;
            sh1_d     = '0;
            sh2_d     = '0;
          end
        end else if (cnt_q == TO_LAST) begin
          cmd_err_d = 1'b1;
          state_d   = S_IDLE;
          cnt_d     = '0;
          sh0_d     = '0;
          sh1_d     = '0;
          sh2_d     = '0;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cmd_alarm_q <= 1'b0;
      sh0_q       <= '0;
      sh1_q       <= '0;
      sh2_q       <= '0;
      mt_q        <= '0;
      mo_q        <= '0;
      st_q        <= '0;
      so_q        <= '0;
      ld_time_q   <= 1'b0;
      ld_alarm_q  <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_alarm_q <= cmd_alarm_d;
      sh0_q       <= sh0_d;
      sh1_q       <= sh1_d;
      sh2_q       <= sh2_d;
      mt_q        <= mt_d;
      mo_q        <= mo_d;
      st_q        <= st_d;
      so_q        <= so_d;
      ld_time_q   <= ld_time_d;
      ld_alarm_q  <= ld_alarm_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  assign ld_time  = ld_time_q;
  assign ld_alarm = ld_alarm_q;
  assign cmd_err  = cmd_err_q;
  assign ld_Mtens = mt_q;
  assign ld_Mones = mo_q;
  assign ld_Stens = st_q;
  assign ld_Sones = so_q;

`ifdef RX_ECHO_EN
  logic       echo_rdy_q, echo_rdy_d;
  logic [7:0] echo_data_q, echo_data_d;

  always_comb begin
    echo_rdy_d  = bu_rx_data_rdy && ((state_q != S_IDLE) || is_cmd);
    echo_data_d = echo_rdy_d ? bu_rx_data : echo_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      echo_rdy_q  <= 1'b0;
      echo_data_q <= 8'h00;
    end else begin
      echo_rdy_q  <= echo_rdy_d;
      echo_data_q <= echo_data_d;
    end
  end

  assign echo_rdy  = echo_rdy_q;
  assign echo_data = echo_data_q;
`else
  assign echo_rdy  = 1'b0;
  assign echo_data = 8'h00;
`endif

endmodule
